rx_decr_fifo_ctrl: RTL and testbench

Parametrised flag and address controller for the MAC receive decryption buffer. It sits between the RX decryption engine, which pushes bytes, and the RX DMA-side reader, which pops them. It drives the write and read ports of the dual-port RX buffer RAM. It generalises the single-depth, CCMP-only controller in three ways: configurable depth and thresholds, a four-way cipher mode with per-mode MIC trailer length, and occupancy, next-empty and sticky error reporting.

---
 rtl/rx_decr_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_rx_decr_fifo_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_decr_fifo_ctrl.sv
// Flag and address controller for the RX decryption buffer. It tracks occupancy and both RAM
// pointers, and raises almost-empty early enough to leave the cipher MIC trailer in the buffer.
module rx_decr_fifo_ctrl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 64,
    parameter int AF_MARGIN    = 3,
    parameter int PLAIN_AE_THR = 8,
    parameter int PROT_AE_THR  = 2
) (
    input  logic                  bbClk,
    input  logic                  hardRstBbClk_n,
    input  logic                  softRstBbClk_p,
    input  logic                  push,
    input  logic                  pop_p,
    input  logic                  flush_p,
    input  logic                  fifoReset,
    input  logic [1:0]            cipherMode,
    input  logic [15:0]           rxPayloadLen,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic                  nextEmpty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  fifoResetInValid
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LVL_FULL  = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LVL_AF    = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0]   LVL_PLAIN = (ADDR_WIDTH + 1)'(PLAIN_AE_THR);
    localparam logic [ADDR_WIDTH:0]   LVL_PROT  = (ADDR_WIDTH + 1)'(PROT_AE_THR);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [15:0]           read_cnt_q, read_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic        rd_en;
    logic        clr;
    logic [15:0] trailer_len;
    logic [15:0] tail_thr;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LVL_FULL);
    assign almostFull = (level_q >= LVL_AF);

    assign wrEn  = push & ~full;
    assign rd_en = pop_p & ~empty;
    assign clr   = softRstBbClk_p | flush_p | fifoReset;

    assign nextEmpty        = (level_q == LVL_ONE) & rd_en & ~wrEn;
    assign fifoResetInValid = fifoReset & (wr_ptr_q == '0) & (rd_ptr_q == '0);

    assign wrAddr    = wr_ptr_q;
    assign rdAddr    = rd_ptr_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    always_comb begin
        trailer_len = 16'd0;
        case (cipherMode)
            2'd1:    trailer_len = 16'd12;
            2'd2:    trailer_len = 16'd20;
            2'd3:    trailer_len = 16'd16;
            default: trailer_len = 16'd0;
        endcase
    end

    // Short frames carry nothing but trailer, so every remaining byte counts as tail.
    assign tail_thr = (rxPayloadLen < trailer_len) ? 16'd0 : (rxPayloadLen - trailer_len);

    always_comb begin
        if (cipherMode == 2'd0) begin
            almostEmpty = (level_q <= LVL_PLAIN);
        end else begin
            almostEmpty = (level_q <= LVL_PROT) | ((read_cnt_q >= tail_thr) & ~empty);
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        read_cnt_d = read_cnt_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            read_cnt_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            if (wrEn) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                if (read_cnt_q != 16'hFFFF) begin
                    read_cnt_d = read_cnt_q + 16'd1;
                end
            end
            if (wrEn && !rd_en) begin
                level_d = level_q + 1'b1;
            end else if (rd_en && !wrEn) begin
                level_d = level_q - 1'b1;
            end
            if (push && full) begin
                ovf_d = 1'b1;
            end
            if (pop_p && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            read_cnt_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            read_cnt_q <= read_cnt_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

endmodule

// File: tb/tb_rx_decr_fifo_ctrl.sv
// Directed bench for rx_decr_fifo_ctrl: a 64-entry instance for flags, tail and flush behaviour,
// plus a 10-entry instance for non-power-of-2 pointer wrap.
module tb_rx_decr_fifo_ctrl;

    logic        bbClk = 1'b0;
    logic        rst_n;
    logic        soft_rst, push, pop_p, flush_p, fifoReset;
    logic [1:0]  cipherMode;
    logic [15:0] rxPayloadLen;
    logic        wrEn, empty, full, almostFull, almostEmpty, nextEmpty;
    logic        overflow, underflow, fifoResetInValid;
    logic [5:0]  wrAddr, rdAddr;
    logic [6:0]  level;

    logic        d10_push, d10_pop;
    logic        d10_wrEn, d10_empty, d10_full, d10_af, d10_ae, d10_ne, d10_ovf, d10_udf, d10_frv;
    logic [3:0]  d10_wrAddr, d10_rdAddr;
    logic [4:0]  d10_level;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt;
    int exp_lvl;

    always #5 bbClk = ~bbClk;

    rx_decr_fifo_ctrl u_dut (
        .bbClk(bbClk), .hardRstBbClk_n(rst_n), .softRstBbClk_p(soft_rst),
        .push(push), .pop_p(pop_p), .flush_p(flush_p), .fifoReset(fifoReset),
        .cipherMode(cipherMode), .rxPayloadLen(rxPayloadLen),
        .wrEn(wrEn), .wrAddr(wrAddr), .rdAddr(rdAddr), .level(level),
        .empty(empty), .full(full), .almostFull(almostFull), .almostEmpty(almostEmpty),
        .nextEmpty(nextEmpty), .overflow(overflow), .underflow(underflow),
        .fifoResetInValid(fifoResetInValid)
    );

    rx_decr_fifo_ctrl #(.ADDR_WIDTH(4), .DEPTH(10)) u_d10 (
        .bbClk(bbClk), .hardRstBbClk_n(rst_n), .softRstBbClk_p(1'b0),
        .push(d10_push), .pop_p(d10_pop), .flush_p(1'b0), .fifoReset(1'b0),
        .cipherMode(2'd0), .rxPayloadLen(16'd0),
        .wrEn(d10_wrEn), .wrAddr(d10_wrAddr), .rdAddr(d10_rdAddr), .level(d10_level),
        .empty(d10_empty), .full(d10_full), .almostFull(d10_af), .almostEmpty(d10_ae),
        .nextEmpty(d10_ne), .overflow(d10_ovf), .underflow(d10_udf),
        .fifoResetInValid(d10_frv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge bbClk);
        #1;
    endtask

    initial begin
        logic [1:0]  tbl_mode [8];
        logic [15:0] tbl_len  [8];
        logic        tbl_exp  [8];
        tbl_mode = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0};
        tbl_len  = '{16'd10, 16'd21, 16'd22, 16'd17, 16'd18, 16'd13, 16'd14, 16'd0};
        tbl_exp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; soft_rst = 1'b0; push = 1'b0; pop_p = 1'b0; flush_p = 1'b0;
        fifoReset = 1'b0; cipherMode = 2'd0; rxPayloadLen = 16'd0;
        d10_push = 1'b0; d10_pop = 1'b0;
        #12;
        chk("rst_level", level, 0);
        chk("rst_wrAddr", wrAddr, 0);
        chk("rst_rdAddr", rdAddr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_almostEmpty", almostEmpty, 1);
        chk("rst_full", full, 0);
        chk("rst_almostFull", almostFull, 0);
        chk("rst_nextEmpty", nextEmpty, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_wrEn", wrEn, 0);
        chk("rst_frv", fifoResetInValid, 0);
        rst_n = 1'b1;
        tick();

        // Fill: 70 pushes, only 63 accepted.
        wr_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            push = 1'b1;
            #1;
            if (wrEn) wr_cnt++;
            chk("fill_wrEn", wrEn, (i < 63) ? 1 : 0);
            tick();
            exp_lvl = (i + 1 < 63) ? i + 1 : 63;
            chk("fill_level", level, exp_lvl);
            chk("fill_ae_none", almostEmpty, (exp_lvl <= 8) ? 1 : 0);
            chk("fill_af", almostFull, (exp_lvl >= 61) ? 1 : 0);
            chk("fill_full", full, (exp_lvl == 63) ? 1 : 0);
            chk("fill_ovf", overflow, (i >= 63) ? 1 : 0);
        end
        push = 1'b0;
        chk("fill_wr_cnt", wr_cnt, 63);
        chk("fill_wrAddr", wrAddr, 63);
        chk("fill_rdAddr", rdAddr, 0);

        // push+pop at full: read only.
        push = 1'b1; pop_p = 1'b1;
        #1;
        chk("full_pp_wrEn", wrEn, 0);
        tick();
        push = 1'b0; pop_p = 1'b0;
        chk("full_pp_level", level, 62);
        chk("full_pp_rdAddr", rdAddr, 1);
        push = 1'b1;
        tick();
        push = 1'b0;
        chk("refill_level", level, 63);
        chk("refill_wrAddr_wrap", wrAddr, 0);

        // Drain: 64 pops, 63 accepted.
        for (int j = 0; j < 64; j++) begin
            pop_p = 1'b1;
            #1;
            chk("drain_nextEmpty", nextEmpty, (j == 62) ? 1 : 0);
            tick();
            chk("drain_level", level, (62 - j > 0) ? 62 - j : 0);
            chk("drain_empty", empty, (j >= 62) ? 1 : 0);
            chk("drain_udf", underflow, (j >= 63) ? 1 : 0);
        end
        pop_p = 1'b0;
        chk("drain_rdAddr_wrap", rdAddr, 0);
        chk("drain_ovf_sticky", overflow, 1);

        // push+pop at empty: write only.
        push = 1'b1; pop_p = 1'b1;
        #1;
        chk("empty_pp_wrEn", wrEn, 1);
        chk("empty_pp_nextEmpty", nextEmpty, 0);
        tick();
        push = 1'b0; pop_p = 1'b0;
        chk("empty_pp_level", level, 1);
        chk("empty_pp_rdAddr", rdAddr, 0);
        chk("empty_pp_wrAddr", wrAddr, 1);
        push = 1'b1;
        repeat (4) tick();
        chk("lvl5_level", level, 5);
        pop_p = 1'b1;
        tick();
        pop_p = 1'b0;
        chk("mid_pp_level", level, 5);
        chk("mid_pp_wrAddr", wrAddr, 6);
        chk("mid_pp_rdAddr", rdAddr, 1);
        repeat (15) tick();
        chk("lvl20_level", level, 20);

        // Flush with push and pop active.
        pop_p = 1'b1; flush_p = 1'b1;
        #1;
        chk("flush_wrEn", wrEn, 1);
        tick();
        push = 1'b0; pop_p = 1'b0; flush_p = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_wrAddr", wrAddr, 0);
        chk("flush_rdAddr", rdAddr, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_udf", underflow, 0);
        chk("flush_empty", empty, 1);

        // fifoReset with nonzero pointers, then with zero pointers.
        push = 1'b1;
        repeat (3) tick();
        chk("fr_pre_wrAddr", wrAddr, 3);
        fifoReset = 1'b1;
        #1;
        chk("fr_frv_rise", fifoResetInValid, 0);
        tick();
        chk("fr_frv_next", fifoResetInValid, 1);
        chk("fr_level", level, 0);
        chk("fr_wrAddr", wrAddr, 0);
        tick();
        chk("fr_frv_hold", fifoResetInValid, 1);
        chk("fr_push_discard", level, 0);
        fifoReset = 1'b0; push = 1'b0;
        #1;
        chk("fr_frv_drop", fifoResetInValid, 0);
        fifoReset = 1'b1;
        #1;
        chk("fr_frv_zero_ptr", fifoResetInValid, 1);
        fifoReset = 1'b0;
        tick();

        // Soft reset.
        push = 1'b1;
        repeat (2) tick();
        chk("sr_pre_level", level, 2);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0; push = 1'b0;
        chk("sr_level", level, 0);
        chk("sr_wrAddr", wrAddr, 0);

        // CCMP tail: tailThr = 40 - 12 = 28.
        cipherMode = 2'd1; rxPayloadLen = 16'd40;
        push = 1'b1;
        repeat (40) tick();
        push = 1'b0;
        chk("ccmp_level", level, 40);
        chk("ccmp_ae_full", almostEmpty, 0);
        for (int j = 0; j < 40; j++) begin
            pop_p = 1'b1;
            #1;
            chk("ccmp_nextEmpty", nextEmpty, (j == 39) ? 1 : 0);
            tick();
            exp_lvl = 39 - j;
            chk("ccmp_ae", almostEmpty,
                ((exp_lvl <= 2) || ((j + 1 >= 28) && (exp_lvl != 0))) ? 1 : 0);
        end
        pop_p = 1'b0;
        chk("ccmp_empty", empty, 1);

        // Per-mode trailer lengths at level 4, readCnt 1.
        flush_p = 1'b1;
        tick();
        flush_p = 1'b0;
        push = 1'b1;
        repeat (5) tick();
        push = 1'b0; pop_p = 1'b1;
        tick();
        pop_p = 1'b0;
        chk("mode_level", level, 4);
        for (int k = 0; k < 8; k++) begin
            cipherMode = tbl_mode[k];
            rxPayloadLen = tbl_len[k];
            #1;
            chk($sformatf("mode%0d_len%0d_ae", tbl_mode[k], tbl_len[k]), almostEmpty, tbl_exp[k]);
        end

        // DEPTH=10 wrap with level held at 3.
        d10_push = 1'b1;
        repeat (3) tick();
        chk("d10_pre_level", d10_level, 3);
        d10_pop = 1'b1;
        for (int i = 0; i < 25; i++) begin
            #1;
            chk("d10_wrAddr", d10_wrAddr, (3 + i) % 10);
            chk("d10_rdAddr", d10_rdAddr, i % 10);
            tick();
            chk("d10_level", d10_level, 3);
        end
        d10_push = 1'b0; d10_pop = 1'b0;
        chk("d10_end_wrAddr", d10_wrAddr, 8);
        chk("d10_end_rdAddr", d10_rdAddr, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
